// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// FSM encodings, the hardwired-zero register index and the operand-match helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_WAIT  = 2'd1,
    HZ_ABORT = 2'd2
  } hz_state_t;

  localparam logic [2:0] REG_ZERO = 3'd0;

  // r0 never carries a real value, so a write to it can never be a hazard source.
  function automatic logic src_hit(input logic       uses,
                                   input logic [2:0] src,
                                   input logic [2:0] dst);
    return uses && (src == dst) && (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with synchronous clear; used only when
// HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall / flush / freeze control for PC, IF/ID, ID/EX and EX/MEM.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [2:0] ex_dst,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  input  logic       err_clr,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       pipe_hold,
  output logic       mem_abort,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_load_stall,
  output logic [CNT_W-1:0] cnt_branch_flush,
  output logic [CNT_W-1:0] cnt_mem_wait
`endif
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] T_LIMIT = TW'(MEM_TIMEOUT);

  hz_state_t     state_r, state_s;
  logic [TW-1:0] wait_cnt_r, wait_cnt_s;
  logic          err_set_s;
  logic          load_use_s;
  logic          freeze_s;

  assign load_use_s = ex_mem_read &&
                      (src_hit(id_uses_rs, id_rs, ex_dst) || src_hit(id_uses_rt, id_rt, ex_dst));
  assign freeze_s   = mem_req && !mem_ready && (state_r != HZ_ABORT);

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= HZ_RUN;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // Next state: a ready in the timeout cycle wins over the abort.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    err_set_s  = 1'b0;
    case (state_r)
      HZ_RUN: begin
        if (freeze_s) begin
          state_s    = HZ_WAIT;
          wait_cnt_s = T_ONE;
        end else begin
          state_s    = HZ_RUN;
          wait_cnt_s = '0;
        end
      end
      HZ_WAIT: begin
        // A withdrawn request also ends the wait; nothing is left to abort.
        if (mem_ready || !mem_req) begin
          state_s    = HZ_RUN;
          wait_cnt_s = '0;
        end else if (wait_cnt_r == T_LIMIT) begin
          state_s    = HZ_ABORT;
          wait_cnt_s = '0;
          err_set_s  = 1'b1;
        end else begin
          state_s    = HZ_WAIT;
          wait_cnt_s = wait_cnt_r + T_ONE;
        end
      end
      HZ_ABORT: begin
        state_s    = HZ_RUN;
        wait_cnt_s = '0;
      end
      default: begin
        state_s    = HZ_RUN;
        wait_cnt_s = '0;
      end
    endcase
  end

  // Sticky timeout flag; a set coinciding with err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err <= 1'b0;
    end else if (err_set_s) begin
      mem_err <= 1'b1;
    end else if (err_clr) begin
      mem_err <= 1'b0;
    end else begin
      mem_err <= mem_err;
    end
  end

  // Pipeline controls in priority order: freeze, branch squash, load-use bubble.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_hold   = 1'b0;
    mem_abort   = 1'b0;
    if (!rst_n) begin
      mem_abort = 1'b0;
    end else begin
      mem_abort = (state_r == HZ_ABORT);
      if (freeze_s) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_hold   = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use_s) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end else begin
        pc_write = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.W(CNT_W)) u_cnt_load (
    .clk(clk), .rst_n(rst_n), .clr(err_clr),
    .inc(!freeze_s && !ex_branch_taken && load_use_s),
    .count(cnt_load_stall)
  );
  hazard_perf_cnt #(.W(CNT_W)) u_cnt_branch (
    .clk(clk), .rst_n(rst_n), .clr(err_clr),
    .inc(!freeze_s && ex_branch_taken),
    .count(cnt_branch_flush)
  );
  hazard_perf_cnt #(.W(CNT_W)) u_cnt_wait (
    .clk(clk), .rst_n(rst_n), .clr(err_clr),
    .inc(freeze_s),
    .count(cnt_mem_wait)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table for the combinational
// priorities plus hand-written sequences for wait, timeout, tie and reset.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
  logic       mem_req, mem_ready, err_clr;
  logic [2:0] id_rs, id_rt, ex_dst;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_abort, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] cnt_load_stall, cnt_branch_flush, cnt_mem_wait;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .err_clr(err_clr),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .pipe_hold(pipe_hold), .mem_abort(mem_abort),
    .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .cnt_load_stall(cnt_load_stall), .cnt_branch_flush(cnt_branch_flush),
    .cnt_mem_wait(cnt_mem_wait)
`endif
  );

  // Observed outputs packed as {pc, ifw, iff, idf, hold, abort, err}.
  logic [6:0] obs;
  assign obs = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_abort, mem_err};

  localparam logic [6:0] O_NORM   = 7'b1100000;
  localparam logic [6:0] O_LU     = 7'b0001000;
  localparam logic [6:0] O_BR     = 7'b1111000;
  localparam logic [6:0] O_HOLD   = 7'b0000100;
  localparam logic [6:0] O_ABORT  = 7'b1100011;
  localparam logic [6:0] O_NORM_E = 7'b1100001;

  typedef struct {
    string      name;
    logic [6:0] outs;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic       rd;
    logic [2:0] dst;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs[11];

  int errors = 0;
  int checks = 0;

  task automatic push_exp(input string name, input logic [6:0] outs);
    exp_t e;
    e.name = name;
    e.outs = outs;
    sb_q.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      if (obs !== e.outs) begin
        errors++;
        $display("FAIL %s: got %b expected %b (pc,ifw,iff,idf,hold,abort,err) t=%0t",
                 e.name, obs, e.outs, $time);
      end
    end
  endtask

  // Called at a falling edge after inputs are driven; leaves at the next falling edge.
  task automatic step(input string name, input logic [6:0] outs);
    push_exp(name, outs);
    #2;
    compare_front();
    @(negedge clk);
  endtask

  task automatic check_state(input string name, input logic [1:0] exp);
    checks++;
    if (dut.state_r !== exp) begin
      errors++;
      $display("FAIL %s: state got %0d expected %0d", name, dut.state_r, exp);
    end
  endtask

  task automatic idle();
    id_rs = 3'd0; id_rt = 3'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_dst = 3'd0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, O_LU};   // load-use on rs
    vecs[1]  = '{3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, O_NORM}; // r0 never stalls
    vecs[2]  = '{3'd5, 3'd3, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, O_NORM}; // rt unused
    vecs[3]  = '{3'd5, 3'd3, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, O_LU};   // rt used
    vecs[4]  = '{3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, O_BR};   // branch over load-use
    vecs[5]  = '{3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, O_BR};   // branch alone
    vecs[6]  = '{3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, O_NORM}; // match but not a load
    vecs[7]  = '{3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, O_LU};   // zero-wait access
    vecs[8]  = '{3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, O_HOLD}; // freeze beats all
    vecs[9]  = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, O_BR};   // release, branch applies
    vecs[10] = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, O_NORM};

    idle();
    rst_n = 1'b0;
    push_exp("reset_outs", O_NORM);
    #2;
    compare_front();
    check_state("reset_state", HZ_RUN);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if ({cnt_load_stall, cnt_branch_flush, cnt_mem_wait} !== 48'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
               cnt_load_stall, cnt_branch_flush, cnt_mem_wait);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
      ex_mem_read = vecs[i].rd; ex_dst = vecs[i].dst;
      ex_branch_taken = vecs[i].br; mem_req = vecs[i].req; mem_ready = vecs[i].rdy;
      step($sformatf("vec%0d", i), vecs[i].exp);
    end
    check_state("after_vectors", HZ_RUN);

    // Four wait cycles, then the access completes.
    idle();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) step("wait_hold", O_HOLD);
    mem_ready = 1'b1;
    step("wait_release", O_NORM);
    check_state("wait_back_to_run", HZ_RUN);
    idle();
    step("wait_idle", O_NORM);

    // Timeout: 1 RUN + 15 WAIT freeze cycles, then a single ABORT cycle.
    // err_clr coincides with the set in the last WAIT cycle; the set must win.
    mem_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      err_clr = (i == 15);
      step("timeout_hold", O_HOLD);
    end
    err_clr = 1'b0;
    step("timeout_abort", O_ABORT);
    mem_req = 1'b0;
    step("err_sticky", O_NORM_E);
    err_clr = 1'b1;
    step("err_clr_cycle", O_NORM_E);
    err_clr = 1'b0;
    step("err_cleared", O_NORM);

    // Ready arriving in the timeout cycle: no abort, no error.
    mem_req = 1'b1;
    for (int i = 0; i < 15; i++) step("tie_hold", O_HOLD);
    mem_ready = 1'b1;
    step("tie_release", O_NORM);
    idle();
    step("tie_no_abort", O_NORM);
    check_state("tie_state", HZ_RUN);

    // Reset asserted in the third WAIT cycle.
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) step("rst_wait_hold", O_HOLD);
    push_exp("rst_wait_before", O_HOLD);
    #2;
    compare_front();
    rst_n = 1'b0;
    push_exp("rst_mid_wait_outs", O_NORM);
    #1;
    compare_front();
    check_state("rst_mid_wait_state", HZ_RUN);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if ({cnt_load_stall, cnt_branch_flush, cnt_mem_wait} !== 48'd0) begin
      errors++;
      $display("FAIL rst_mid_wait_counters: got %0d/%0d/%0d expected 0/0/0",
               cnt_load_stall, cnt_branch_flush, cnt_mem_wait);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step("post_reset_idle", O_NORM);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
